// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage.
//   u32 / u64      : plain word types
//   fetch_state_t  : fetch FSM state encoding
//   ibus_req_t     : instruction-bus request (valid + address)
//   ibus_resp_t    : instruction-bus response (data_ok + word)
package fetch_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    localparam u64 PC_STEP = 64'd4;

    // Instructions are word aligned; the low two bits of a target are dropped.
    function automatic u64 align_pc(input u64 pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-bus request
// outstanding at a time and hands each returned word to decode over a
// valid/ready handshake. Execute redirects flush the wrong-path fetch.
//
// Ports
//   clk            : clock, rising edge
//   reset          : asynchronous reset, active low
//   ireq_valid/addr: instruction-bus request (address held while valid)
//   iresp_data_ok  : bus completes the outstanding request this cycle
//   iresp_data     : returned instruction word
//   redirect_valid : execute requests a PC change to redirect_pc
//   out_valid/ready: handshake towards decode
//   out_pc         : PC of the presented instruction
//   out_raw_instr  : presented instruction word
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | just out of reset, launches the first request next cycle
// S_REQ     | request outstanding at req_addr, waiting for data_ok
// S_HOLD    | instruction held on out_*, waiting for decode to accept
// S_DISCARD | wrong-path request still on the bus, its data will be dropped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter u64 PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_raw_instr
);

    fetch_state_t state_q, state_d;
    u64           fetch_pc_q, fetch_pc_d;
    u64           req_addr_q, req_addr_d;
    u32           instr_q, instr_d;
    u64           out_pc_q, out_pc_d;

    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    u64           redir_pc;
    u64           seq_pc;

    assign iresp    = '{data_ok: iresp_data_ok, data: iresp_data};
    assign redir_pc = align_pc(redirect_pc);
    assign seq_pc   = out_pc_q + PC_STEP;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        out_pc_d   = out_pc_q;
        ireq       = '0;
        out_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    req_addr_d = redir_pc;
                end else begin
                    req_addr_d = fetch_pc_q;
                end
                state_d = S_REQ;
            end

            S_REQ: begin
                ireq.valid = 1'b1;
                ireq.addr  = req_addr_q;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    if (iresp.data_ok) begin
                        // Bus is free again, so the new target can go out at once.
                        req_addr_d = redir_pc;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (iresp.data_ok) begin
                    instr_d  = iresp.data;
                    out_pc_d = req_addr_q;
                    state_d  = S_HOLD;
                end
            end

            S_HOLD: begin
                out_valid = 1'b1;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                    req_addr_d = redir_pc;
                    state_d    = S_REQ;
                end else if (out_ready) begin
                    fetch_pc_d = seq_pc;
                    req_addr_d = seq_pc;
                    state_d    = S_REQ;
                end
            end

            S_DISCARD: begin
                // The stale request cannot be withdrawn; keep presenting it.
                ireq.valid = 1'b1;
                ireq.addr  = req_addr_q;
                if (redirect_valid) begin
                    fetch_pc_d = redir_pc;
                end
                if (iresp.data_ok) begin
                    // A redirect landing on the stale data_ok must not strand
                    // the FSM waiting for a response that will never come.
                    req_addr_d = redirect_valid ? redir_pc : fetch_pc_q;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= PC_RESET;
            req_addr_q <= PC_RESET;
            instr_q    <= '0;
            out_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            out_pc_q   <= out_pc_d;
        end
    end

    assign ireq_valid    = ireq.valid;
    assign ireq_addr     = ireq.addr;
    assign out_pc        = out_pc_q;
    assign out_raw_instr = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. A second instance with a top-of-memory
// reset PC shares the stimulus and is used for the wrap-around case.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_raw_instr;

    logic        w_ireq_valid;
    logic [63:0] w_ireq_addr;
    logic        w_out_valid;
    logic [63:0] w_out_pc;
    logic [31:0] w_out_raw_instr;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_raw_instr(out_raw_instr)
    );

    fetch_stage #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset),
        .ireq_valid(w_ireq_valid), .ireq_addr(w_ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_out_pc), .out_raw_instr(w_out_raw_instr)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } out_t;

    out_t        exp_out[$];
    logic [63:0] exp_req[$];
    int          total = 0;
    int          bad   = 0;
    bit          new_req = 1'b1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 32'h0000_0513;
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40; i++) begin
            if (ireq_valid) break;
            tick();
        end
        check_eq("req_timeout", ireq_valid, 1);
    endtask

    // Complete the outstanding request after lat cycles.
    task automatic respond(input int lat, input bit push_out, input bit exp_valid,
                           input bit redir, input logic [63:0] rpc);
        repeat (lat) tick();
        iresp_data_ok = 1'b1;
        iresp_data    = mem(ireq_addr);
        if (redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = rpc;
        end
        if (push_out) exp_out.push_back('{ireq_addr, mem(ireq_addr)});
        tick();
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        check_eq("lat_out_valid", out_valid, exp_valid);
    endtask

    // Monitor: new requests against expected addresses, transfers against
    // the expected instruction stream.
    always @(negedge clk) begin
        out_t o;
        if (!reset) begin
            new_req = 1'b1;
        end else begin
            if (ireq_valid && new_req) begin
                if (exp_req.size() == 0) begin
                    check_eq("req_extra", exp_req.size(), 1);
                end else begin
                    check_eq("req_addr", ireq_addr, exp_req.pop_front());
                end
            end
            new_req = !ireq_valid || iresp_data_ok;
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_out.size() == 0) begin
                    check_eq("out_extra", exp_out.size(), 1);
                end else begin
                    o = exp_out.pop_front();
                    check_eq("out_pc", out_pc, o.pc);
                    check_eq("out_instr", {32'h0, out_raw_instr}, {32'h0, o.instr});
                end
            end
        end
    end

    initial begin
        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        repeat (3) tick();
        check_eq("rst_ireq_valid", ireq_valid, 0);
        check_eq("rst_ireq_addr", ireq_addr, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_out_instr", out_raw_instr, 0);

        // Sequential fetches with decode always ready.
        exp_req.push_back(64'h8000_0000);
        exp_req.push_back(64'h8000_0004);
        exp_req.push_back(64'h8000_0008);
        exp_req.push_back(64'h8000_000C);
        reset = 1'b1;
        tick();
        check_eq("first_req", ireq_valid, 1);
        check_eq("first_addr", ireq_addr, 64'h8000_0000);
        respond(2, 1, 1, 0, '0);
        check_eq("first_out_pc", out_pc, 64'h8000_0000);
        check_eq("first_out_instr", out_raw_instr, 32'h0000_0513);
        for (int i = 0; i < 2; i++) begin
            wait_req();
            respond(2, 1, 1, 0, '0);
        end

        // Decode stalls for 5 cycles in S_HOLD.
        wait_req();
        out_ready = 1'b0;
        respond(1, 1, 1, 0, '0);
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_pc", out_pc, 64'h8000_000C);
            check_eq("hold_instr", out_raw_instr, mem(64'h8000_000C));
            check_eq("hold_no_req", ireq_valid, 0);
            tick();
        end
        exp_req.push_back(64'h8000_0010);
        exp_req.push_back(64'h8000_0014);
        out_ready = 1'b1;
        wait_req();
        respond(2, 1, 1, 0, '0);

        // Redirect during an outstanding request: stale data discarded.
        wait_req();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check_eq("disc_req_valid", ireq_valid, 1);
        check_eq("disc_req_addr", ireq_addr, 64'h8000_0014);
        exp_req.push_back(64'h8000_0100);
        respond(2, 0, 0, 0, '0);
        check_eq("redir_addr", ireq_addr, 64'h8000_0100);
        exp_req.push_back(64'h8000_0104);
        respond(2, 1, 1, 0, '0);

        // Redirect coinciding with data_ok, unaligned target.
        wait_req();
        exp_req.push_back(64'h8000_0200);
        respond(1, 0, 0, 1, 64'h8000_0203);
        check_eq("same_cyc_valid", ireq_valid, 1);
        check_eq("same_cyc_addr", ireq_addr, 64'h8000_0200);
        exp_req.push_back(64'h8000_0204);
        respond(1, 1, 1, 0, '0);

        // Redirect while an instruction is held.
        wait_req();
        out_ready = 1'b0;
        respond(1, 0, 1, 0, '0);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        exp_req.push_back(64'h8000_0300);
        tick();
        redirect_valid = 1'b0;
        check_eq("hold_redir_valid", out_valid, 0);
        check_eq("hold_redir_addr", ireq_addr, 64'h8000_0300);
        exp_req.push_back(64'h8000_0304);
        respond(2, 1, 1, 0, '0);
        wait_req();
        tick();

        // Reset mid-request; a stale response during reset is ignored.
        reset = 1'b0;
        #1;
        check_eq("mid_rst_req", ireq_valid, 0);
        check_eq("mid_rst_addr", ireq_addr, 0);
        check_eq("mid_rst_pc", out_pc, 0);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hDEAD_BEEF;
        tick();
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        check_eq("mid_rst_out", out_valid, 0);
        exp_req.push_back(64'h8000_0000);
        exp_req.push_back(64'h8000_0004);
        reset = 1'b1;
        wait_req();
        check_eq("wrap_first_addr", w_ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        respond(2, 1, 1, 0, '0);
        check_eq("wrap_out_valid", w_out_valid, 1);
        check_eq("wrap_out_pc", w_out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check_eq("wrap_req_valid", w_ireq_valid, 1);
        check_eq("wrap_req_addr", w_ireq_addr, 64'h0);
        repeat (2) tick();

        check_eq("out_q_left", exp_out.size(), 0);
        check_eq("req_q_left", exp_req.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
